// File: rtl/w0rm_regfile_wb_arbiter.sv
// Two-source write-back arbiter for the single register-file write port.
// Latency: accept at edge E0, rf_write_enable high after E1; the register file commits at E2.
// Backpressure: each source has one holding buffer. X_ready is high when that buffer is empty, or when it is granted this cycle. Ready is low during flush.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   flush                  discards both buffers and suppresses the next write
//   alu_wb_*, mem_wb_*     valid/ready/addr/data write-back requests
//   rf_write_*             registered register-file write port
//   wb_source              registered source of the current write: 0 = ALU, 1 = MEM
//   pending_mask           one bit per register with a write buffered or on the port
//
// Optional feature: define W0RM_WB_ROUND_ROBIN_EN to replace fixed MEM>ALU
// priority with round-robin when both buffers are full.
module w0rm_regfile_wb_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 16,
    localparam int REG_ADDR_BITS = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     alu_wb_valid,
    output logic                     alu_wb_ready,
    input  logic [REG_ADDR_BITS-1:0] alu_wb_addr,
    input  logic [DATA_WIDTH-1:0]    alu_wb_data,
    input  logic                     mem_wb_valid,
    output logic                     mem_wb_ready,
    input  logic [REG_ADDR_BITS-1:0] mem_wb_addr,
    input  logic [DATA_WIDTH-1:0]    mem_wb_data,
    output logic                     rf_write_enable,
    output logic [REG_ADDR_BITS-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0]    rf_write_data,
    output logic                     wb_source,
    output logic [NUM_REGISTERS-1:0] pending_mask
);

    logic                     alu_full;
    logic [REG_ADDR_BITS-1:0] alu_addr;
    logic [DATA_WIDTH-1:0]    alu_data;
    logic                     mem_full;
    logic [REG_ADDR_BITS-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_data;

    logic grant_alu;
    logic grant_mem;
    logic alu_accept;
    logic mem_accept;

`ifdef W0RM_WB_ROUND_ROBIN_EN
    // Source granted most recently; resets to ALU so MEM wins the first tie.
    logic last_was_mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_was_mem <= 1'b0;
        end else if (grant_mem) begin
            last_was_mem <= 1'b1;
        end else if (grant_alu) begin
            last_was_mem <= 1'b0;
        end
    end
`endif

    // Grants are suppressed during flush so the buffers are dropped and not written.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!flush) begin
            if (alu_full && mem_full) begin
`ifdef W0RM_WB_ROUND_ROBIN_EN
                grant_mem = !last_was_mem;
                grant_alu = last_was_mem;
`else
                grant_mem = 1'b1;
`endif
            end else begin
                grant_alu = alu_full;
                grant_mem = mem_full;
            end
        end
    end

    // A granted buffer can be refilled at the same edge it drains.
    assign alu_wb_ready = !flush && (!alu_full || grant_alu);
    assign mem_wb_ready = !flush && (!mem_full || grant_mem);
    assign alu_accept   = alu_wb_valid && alu_wb_ready;
    assign mem_accept   = mem_wb_valid && mem_wb_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_full <= 1'b0;
            alu_addr <= '0;
            alu_data <= '0;
        end else if (flush) begin
            alu_full <= 1'b0;
        end else if (alu_accept) begin
            alu_full <= 1'b1;
            alu_addr <= alu_wb_addr;
            alu_data <= alu_wb_data;
        end else if (grant_alu) begin
            alu_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_full <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (flush) begin
            mem_full <= 1'b0;
        end else if (mem_accept) begin
            mem_full <= 1'b1;
            mem_addr <= mem_wb_addr;
            mem_data <= mem_wb_data;
        end else if (grant_mem) begin
            mem_full <= 1'b0;
        end
    end

    // Address, data and source hold their values when there is no grant.
    // Only the enable drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            wb_source       <= 1'b0;
        end else begin
            rf_write_enable <= grant_alu || grant_mem;
            if (grant_mem) begin
                rf_write_addr <= mem_addr;
                rf_write_data <= mem_data;
                wb_source     <= 1'b1;
            end else if (grant_alu) begin
                rf_write_addr <= alu_addr;
                rf_write_data <= alu_data;
                wb_source     <= 1'b0;
            end
        end
    end

    function automatic logic [NUM_REGISTERS-1:0] onehot(input logic [REG_ADDR_BITS-1:0] a);
        logic [NUM_REGISTERS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    always_comb begin
        pending_mask = '0;
        if (alu_full) begin
            pending_mask = pending_mask | onehot(alu_addr);
        end
        if (mem_full) begin
            pending_mask = pending_mask | onehot(mem_addr);
        end
        if (rf_write_enable) begin
            pending_mask = pending_mask | onehot(rf_write_addr);
        end
    end

endmodule

// File: tb/tb_w0rm_regfile_wb_arbiter.sv
module tb_w0rm_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        alu_wb_valid;
    logic        alu_wb_ready;
    logic [3:0]  alu_wb_addr;
    logic [31:0] alu_wb_data;
    logic        mem_wb_valid;
    logic        mem_wb_ready;
    logic [3:0]  mem_wb_addr;
    logic [31:0] mem_wb_data;
    logic        rf_write_enable;
    logic [3:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        wb_source;
    logic [15:0] pending_mask;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        src;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] rf_model [16];
    int          tests = 0;
    int          fails = 0;
    int          wr_cnt = 0;

    always #5 clk = ~clk;

    w0rm_regfile_wb_arbiter #(.DATA_WIDTH(32), .NUM_REGISTERS(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .alu_wb_valid    (alu_wb_valid),
        .alu_wb_ready    (alu_wb_ready),
        .alu_wb_addr     (alu_wb_addr),
        .alu_wb_data     (alu_wb_data),
        .mem_wb_valid    (mem_wb_valid),
        .mem_wb_ready    (mem_wb_ready),
        .mem_wb_addr     (mem_wb_addr),
        .mem_wb_data     (mem_wb_data),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .wb_source       (wb_source),
        .pending_mask    (pending_mask)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [31:0] d, input logic s);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.src  = s;
        exp_q.push_back(e);
    endtask

    // Advance one edge and score any write that appeared on the port.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (rf_write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", {63'd0, rf_write_enable}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {60'd0, rf_write_addr}, {60'd0, e.addr});
                check("wr_data", {32'd0, rf_write_data}, {32'd0, e.data});
                check("wr_src",  {63'd0, wb_source},     {63'd0, e.src});
                rf_model[rf_write_addr] = rf_write_data;
                wr_cnt++;
            end
        end
    endtask

    task automatic idle_inputs();
        alu_wb_valid = 1'b0;
        mem_wb_valid = 1'b0;
        alu_wb_addr  = 4'd0;
        alu_wb_data  = 32'd0;
        mem_wb_addr  = 4'd0;
        mem_wb_data  = 32'd0;
    endtask

    initial begin
        int base;
        int na;
        int nm;
        logic ar;
        logic mr;
        for (int r = 0; r < 16; r++) rf_model[r] = 32'd0;
        reset = 1'b1;
        flush = 1'b0;
        idle_inputs();

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_we",      {63'd0, rf_write_enable}, 64'd0);
        check("rst_addr",    {60'd0, rf_write_addr},   64'd0);
        check("rst_data",    {32'd0, rf_write_data},   64'd0);
        check("rst_src",     {63'd0, wb_source},       64'd0);
        check("rst_pending", {48'd0, pending_mask},    64'd0);
        check("rst_alu_rdy", {63'd0, alu_wb_ready},    64'd1);
        check("rst_mem_rdy", {63'd0, mem_wb_ready},    64'd1);

        // Single ALU write: latency and pending mask lifetime
        alu_wb_valid = 1'b1;
        alu_wb_addr  = 4'd3;
        alu_wb_data  = 32'hDEADBEEF;
        #1;
        check("t1_rdy", {63'd0, alu_wb_ready}, 64'd1);
        push(4'd3, 32'hDEADBEEF, 1'b0);
        tick();
        idle_inputs();
        check("t1_we_not_yet", {63'd0, rf_write_enable}, 64'd0);
        check("t1_pend_buf",   {48'd0, pending_mask},    64'h0008);
        tick();
        check("t1_we",        {63'd0, rf_write_enable}, 64'd1);
        check("t1_pend_port", {48'd0, pending_mask},    64'h0008);
        tick();
        check("t1_we_done",   {63'd0, rf_write_enable}, 64'd0);
        check("t1_pend_done", {48'd0, pending_mask},    64'd0);
        check("t1_addr_hold", {60'd0, rf_write_addr},   64'd3);
        check("t1_rf3",       {32'd0, rf_model[3]},     64'hDEADBEEF);

        // Same destination from both sources: MEM then ALU, ALU value final
        alu_wb_valid = 1'b1; alu_wb_addr = 4'd5; alu_wb_data = 32'h11;
        mem_wb_valid = 1'b1; mem_wb_addr = 4'd5; mem_wb_data = 32'h22;
        #1;
        check("t2_alu_rdy0", {63'd0, alu_wb_ready}, 64'd1);
        check("t2_mem_rdy0", {63'd0, mem_wb_ready}, 64'd1);
        push(4'd5, 32'h22, 1'b1);
        push(4'd5, 32'h11, 1'b0);
        tick();
        idle_inputs();
        #1;
        check("t2_alu_rdy_low", {63'd0, alu_wb_ready}, 64'd0);
        check("t2_mem_rdy",     {63'd0, mem_wb_ready}, 64'd1);
        check("t2_pend",        {48'd0, pending_mask}, 64'h0020);
        tick();
        check("t2_alu_rdy_back", {63'd0, alu_wb_ready}, 64'd1);
        tick();
        tick();
        check("t2_rf5_final", {32'd0, rf_model[5]}, 64'h11);

        // ALU streams eight results back to back
        base = wr_cnt;
        for (int i = 0; i < 8; i++) begin
            alu_wb_valid = 1'b1;
            alu_wb_addr  = 4'(i);
            alu_wb_data  = 32'h100 + 32'(i);
            #1;
            check("t3_rdy", {63'd0, alu_wb_ready}, 64'd1);
            push(4'(i), 32'h100 + 32'(i), 1'b0);
            tick();
            if (i > 0) check("t3_we", {63'd0, rf_write_enable}, 64'd1);
        end
        idle_inputs();
        tick();
        check("t3_we_last", {63'd0, rf_write_enable}, 64'd1);
        tick();
        check("t3_count", 64'(wr_cnt - base), 64'd8);

        // Flush with both buffers full
        alu_wb_valid = 1'b1; alu_wb_addr = 4'd1; alu_wb_data = 32'hA;
        mem_wb_valid = 1'b1; mem_wb_addr = 4'd2; mem_wb_data = 32'hB;
        tick();
        idle_inputs();
        flush = 1'b1;
        #1;
        check("t4_alu_rdy", {63'd0, alu_wb_ready}, 64'd0);
        check("t4_mem_rdy", {63'd0, mem_wb_ready}, 64'd0);
        tick();
        flush = 1'b0;
        check("t4_we",   {63'd0, rf_write_enable}, 64'd0);
        check("t4_pend", {48'd0, pending_mask},    64'd0);
        tick();
        check("t4_we2",  {63'd0, rf_write_enable}, 64'd0);

        // Reset while both buffers are full and a write is on the port
        alu_wb_valid = 1'b1; alu_wb_addr = 4'd8; alu_wb_data = 32'h88;
        mem_wb_valid = 1'b1; mem_wb_addr = 4'd7; mem_wb_data = 32'h77;
        push(4'd7, 32'h77, 1'b1);
        tick();
        alu_wb_valid = 1'b0;
        mem_wb_addr  = 4'd9;
        mem_wb_data  = 32'h99;
        #1;
        check("t5_mem_refill_rdy", {63'd0, mem_wb_ready}, 64'd1);
        tick();
        idle_inputs();
        check("t5_we_before", {63'd0, rf_write_enable}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t5_we",   {63'd0, rf_write_enable}, 64'd0);
        check("t5_addr", {60'd0, rf_write_addr},   64'd0);
        check("t5_data", {32'd0, rf_write_data},   64'd0);
        check("t5_src",  {63'd0, wb_source},       64'd0);
        check("t5_pend", {48'd0, pending_mask},    64'd0);
        tick();
        tick();
        tick();
        check("t5_no_writes", {63'd0, rf_write_enable}, 64'd0);

`ifdef W0RM_WB_ROUND_ROBIN_EN
        // Both sources stream three results each: grants alternate, MEM first
        push(4'd10, 32'hC0, 1'b1);
        push(4'd11, 32'hA0, 1'b0);
        push(4'd10, 32'hC1, 1'b1);
        push(4'd11, 32'hA1, 1'b0);
        push(4'd10, 32'hC2, 1'b1);
        push(4'd11, 32'hA2, 1'b0);
        na = 0;
        nm = 0;
        for (int c = 0; c < 12; c++) begin
            alu_wb_valid = (na < 3);
            alu_wb_addr  = 4'd11;
            alu_wb_data  = 32'hA0 + 32'(na);
            mem_wb_valid = (nm < 3);
            mem_wb_addr  = 4'd10;
            mem_wb_data  = 32'hC0 + 32'(nm);
            #1;
            ar = alu_wb_valid && alu_wb_ready;
            mr = mem_wb_valid && mem_wb_ready;
            tick();
            if (ar) na++;
            if (mr) nm++;
        end
        idle_inputs();
`else
        na = 0;
        nm = 0;
        ar = 1'b0;
        mr = 1'b0;
`endif

        check("end_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/w0rm_regfile_wb_arbiter.md
Name: w0rm_regfile_wb_arbiter

Overview:
- Shares the single register-file write port (write addr/enable/data) between two write-back requesters: ALU result path and memory load path.
- Each requester has a valid/ready handshake feeding a one-entry holding buffer; the arbiter drains one buffer per cycle into registered write-port outputs.
- Exports a pending-write mask that decode/rfetch stall logic uses for RAW hazard detection.

Parameters:
- DATA_WIDTH, 32, width of write data
- NUM_REGISTERS, 16, register count; REG_ADDR_BITS = ceil(log2(NUM_REGISTERS)), a derived localparam (4 at default)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; discards buffered writes
- alu_wb_valid  in  1  ALU result offered
- alu_wb_ready  out  1  ALU result accepted when valid&&ready at posedge
- alu_wb_addr  in  REG_ADDR_BITS  ALU destination register
- alu_wb_data  in  DATA_WIDTH  ALU result
- mem_wb_valid  in  1  load result offered
- mem_wb_ready  out  1  load result accepted when valid&&ready at posedge
- mem_wb_addr  in  REG_ADDR_BITS  load destination register
- mem_wb_data  in  DATA_WIDTH  load data
- rf_write_enable  out  1  to register-file write enable, registered
- rf_write_addr  out  REG_ADDR_BITS  to register-file write address, registered
- rf_write_data  out  DATA_WIDTH  to register-file write data, registered
- wb_source  out  1  source of current rf_write: 0 = ALU, 1 = MEM, registered
- pending_mask  out  NUM_REGISTERS  bit r set while a write to r is buffered or on the write port

Behaviour:
- Reset, which takes priority over everything: both buffers empty, rf_write_enable=0, rf_write_addr=0, rf_write_data=0, wb_source=0, round-robin pointer = ALU-last (MEM wins first), pending_mask=0.
- Buffers: each holds full/addr/data. X_ready = !flush && (!X_full || X_granted_this_cycle), combinational. An accept at edge E loads the buffer and sets full.
- Arbitration, combinational over full buffers:
  - Only one full: that one is granted.
  - Both full: MEM wins (fixed priority; loads are older).
  - Neither full: no grant.
- Grant at edge E: rf_write_* and wb_source load from the winner's buffer and rf_write_enable=1. The buffer clears unless refilled at the same edge.
- With no grant, rf_write_enable=0 and rf_write_addr/rf_write_data hold their last value.
- Latency: accept at E0 -> rf_write_enable high after E1 -> register file commits at E2.
- Throughput: one write per cycle total. A single streaming source sustains 1/cycle because ready stays high while its buffer is granted.
- Loser starvation: the ALU can be blocked for consecutive cycles while MEM streams. This is accepted in fixed-priority mode.
- Same destination in both buffers: writes issue in grant order (MEM then ALU), so the ALU value is final.
- Flush, when not in reset: at the edge, both buffers are cleared, rf_write_enable=0, and there is no accept (ready low throughout the flush cycle). A write already on the port at the flush edge still completes, because the register file samples it at that edge.
- pending_mask is combinational OR of:
  - one-hot(alu addr) if ALU buffer full
  - one-hot(mem addr) if MEM buffer full
  - one-hot(rf_write_addr) if rf_write_enable

Optional Feature:
- Macro W0RM_WB_ROUND_ROBIN_EN.
- Defined: when both buffers are full, the source not granted most recently wins. The pointer updates on every grant to the granted source.
- Undefined: fixed MEM>ALU priority as above; the pointer logic is absent.

Test Plan:
- Reset, then ALU valid at cycle 1 with addr=3, data=0xDEADBEEF -> rf_write_enable=1 with addr 3 and that data exactly one cycle after the accept edge, wb_source=0; pending_mask=0x0008 for 2 cycles, then 0.
- ALU (addr 5, 0x11) and MEM (addr 5, 0x22) accepted at the same edge -> MEM write first, ALU write next cycle. Final reg5 = 0x11 (checked through a register-file model). alu_wb_ready low for one cycle.
- ALU streams valid for 8 cycles with no MEM -> ready held high, 8 consecutive rf_write_enable pulses with data in order.
- Both buffers full, flush asserted for 1 cycle -> no rf_write_enable the following cycle, pending_mask=0 after the edge, both readys low during flush.
- reset asserted while both buffers full and rf_write_enable=1 -> next cycle all outputs equal reset values and no further writes.
- With W0RM_WB_ROUND_ROBIN_EN, both sources streaming for 6 cycles -> wb_source sequence 1,0,1,0,1,0.
